// File: rtl/vga_pkg.sv
// Shared constants, flip-state encoding and RAM sizing helper for the
// double-buffered VGA image store.
package vga_pkg;

    localparam int VGA_X_OFFSET   = 240;
    localparam int VGA_IMG_XBITS  = 7;
    localparam int VGA_IMG_YBITS  = 7;
    localparam int VGA_SCALE_LOG2 = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } flip_state_t;

    // The second bank adds one address bit above the per-bank index.
    function automatic int ram_aw(input int buf_aw, input int num_buf);
        return (num_buf == 2) ? buf_aw + 1 : buf_aw;
    endfunction

endpackage

// File: rtl/dual_port_ram_sync.sv
// Simple dual-port synchronous RAM: port a writes, port b reads.
// A same-address read and write in one cycle returns the old word.
module dual_port_ram_sync #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    output logic [DATA_WIDTH-1:0] o_dout_b
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we_a)
            r_mem[i_addr_a] <= i_din_a;
        o_dout_b <= r_mem[i_addr_b];
    end

endmodule

// File: rtl/vga_image_dbuf.sv
// Double-buffered low-res image store scaled onto the VGA grid by a
// power-of-two zoom; page flips are deferred to frame start.
module vga_image_dbuf
    import vga_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               IMG_XBITS  = VGA_IMG_XBITS,
    parameter int               IMG_YBITS  = VGA_IMG_YBITS,
    parameter int               SCALE_LOG2 = VGA_SCALE_LOG2,
    parameter int               X_OFFSET   = VGA_X_OFFSET,
    parameter int               NUM_BUF    = 2,
    parameter logic [DATA_W-1:0] BG_COLOR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              frame_start,
    input  logic              image_we,
    input  logic [DATA_W-1:0] image_data,
    input  logic [15:0]       address,
    input  logic              swap_req,
    output logic [DATA_W-1:0] image_rgb,
    output logic              pix_valid,
    output logic              front_buf,
    output logic              swap_pending
);

    localparam int BUF_AW = IMG_XBITS + IMG_YBITS;
    localparam int RAM_AW = ram_aw(BUF_AW, NUM_BUF);
    localparam int DEPTH  = 1 << BUF_AW;
    localparam int WIN_W  = 1 << (IMG_XBITS + SCALE_LOG2);
    localparam int WIN_H  = 1 << (IMG_YBITS + SCALE_LOG2);

    flip_state_t         r_state, w_state_nx;
    logic                r_front, w_front_nx;

    logic                r_we, r_wvalid, r_wbank;
    logic [DATA_W-1:0]   r_wdata;
    logic [BUF_AW-1:0]   r_widx;
    logic                w_wvalid;

    logic [10:0]         w_rel_x;
    logic                w_in_win;
    logic [IMG_YBITS-1:0] w_ry;
    logic [IMG_XBITS-1:0] w_rx;
    logic [RAM_AW-1:0]   w_waddr, w_raddr;
    logic [DATA_W-1:0]   w_dout;
    logic                r_inwin_d;
    logic [DATA_W-1:0]   r_rgb;
    logic                r_pix_valid;

    // Address 0 belongs to the console; image words live at 1..DEPTH.
    assign w_wvalid = (address != 16'd0) && ({16'd0, address} <= 32'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_wvalid <= 1'b0;
            r_wbank  <= 1'b0;
            r_wdata  <= '0;
            r_widx   <= '0;
        end else begin
            r_we     <= image_we;
            r_wvalid <= w_wvalid;
            r_wbank  <= (NUM_BUF == 2) ? ~r_front : 1'b0;
            r_wdata  <= image_data;
            r_widx   <= BUF_AW'(address - 16'd1);
        end
    end

    assign w_rel_x  = {1'b0, pixel_x} - 11'(X_OFFSET);
    assign w_in_win = !w_rel_x[10] && (32'(w_rel_x) < WIN_W) && (32'(pixel_y) < WIN_H);
    assign w_ry     = pixel_y[SCALE_LOG2 +: IMG_YBITS];
    assign w_rx     = w_rel_x[SCALE_LOG2 +: IMG_XBITS];

    generate
        if (NUM_BUF == 2) begin : g_two_bank
            assign w_waddr = {r_wbank, r_widx};
            assign w_raddr = {r_front, w_ry, w_rx};
        end else begin : g_one_bank
            assign w_waddr = r_widx;
            assign w_raddr = {w_ry, w_rx};
        end
    endgenerate

    dual_port_ram_sync #(
        .ADDR_WIDTH (RAM_AW),
        .DATA_WIDTH (DATA_W)
    ) u_ram (
        .clk      (clk),
        .i_we_a   (r_we & r_wvalid),
        .i_addr_a (w_waddr),
        .i_din_a  (r_wdata),
        .i_addr_b (w_raddr),
        .o_dout_b (w_dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inwin_d   <= 1'b0;
            r_rgb       <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_inwin_d   <= w_in_win;
            r_rgb       <= r_inwin_d ? w_dout : BG_COLOR;
            r_pix_valid <= r_inwin_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_front <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_front <= w_front_nx;
        end
    end

    // A request that coincides with frame start is applied at once.
    always_comb begin
        w_state_nx = r_state;
        w_front_nx = r_front;
        if (NUM_BUF == 2) begin
            case (r_state)
                IDLE: begin
                    if (swap_req) begin
                        if (frame_start)
                            w_front_nx = ~r_front;
                        else
                            w_state_nx = PENDING;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        w_front_nx = ~r_front;
                        w_state_nx = IDLE;
                    end
                end
            endcase
        end
    end

    assign image_rgb    = r_rgb;
    assign pix_valid    = r_pix_valid;
    assign front_buf    = r_front;
    assign swap_pending = (r_state == PENDING);

endmodule

// File: doc/vga_image_dbuf.md
Name: vga_image_dbuf

Overview:
- Parametrised, double-buffered successor to the VGA image frame buffer in the AHB_VGA subsystem.
- Stores a low-resolution image written over the bus-side address/data interface and scales it onto the VGA pixel grid with an integer power-of-two zoom at a configurable X offset.
- Outputs background colour outside the image window.
- Page flips between two banks are synchronised to frame start, so software can redraw without tearing.

Parameters:
- DATA_W, 8: pixel colour width (RGB332 by default).
- IMG_XBITS, 7: log2 image width in stored pixels (default 128).
- IMG_YBITS, 7: log2 image height in stored pixels (default 128).
- SCALE_LOG2, 2: log2 of zoom factor; each stored pixel covers 2^SCALE_LOG2 by 2^SCALE_LOG2 screen pixels. Legal range 0..3.
- X_OFFSET, 240: first screen column of the image window; columns to its left belong to the text region.
- NUM_BUF, 2: number of image banks, 1 or 2.
- BG_COLOR, 8'h00: colour output outside the window.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_x  in  10  current VGA column
- pixel_y  in  10  current VGA row
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- image_we  in  1  bus write strobe for the image region
- image_data  in  DATA_W  write data
- address  in  16  bus word address; 0 is reserved for the console
- swap_req  in  1  one-cycle pulse requesting a page flip
- image_rgb  out  DATA_W  pixel colour, 2-cycle latency from pixel_x/pixel_y
- pix_valid  out  1  registered "inside window", aligned with image_rgb
- front_buf  out  1  bank currently displayed
- swap_pending  out  1  flip requested, not yet applied

Behaviour:
- Reset values (asynchronous): image_rgb=0, pix_valid=0, front_buf=0, swap_pending=0, write stage cleared. RAM contents are not reset.
- Derived widths:
  - BUF_AW = IMG_XBITS+IMG_YBITS.
  - RAM_AW = BUF_AW+1 when NUM_BUF=2, else BUF_AW.
  - Buffer depth D = 2^BUF_AW.
- Write path:
  - Stage 1 registers image_we, image_data and buf_idx = address-1 (16-bit, wraps).
  - Stage 1 also registers the write-valid condition: address in 1..D inclusive.
  - Stage 2: the RAM write occurs on the next edge if the registered we and the registered valid condition are both true.
  - Write target bank: ~front_buf when NUM_BUF=2, else bank 0.
  - The bank is sampled at stage 1.
  - RAM address = {bank, buf_idx[BUF_AW-1:0]}.
  - Address 0 and addresses above D are dropped silently.
- Read path:
  - Cycle 0 computes rel_x = {1'b0,pixel_x} - X_OFFSET as an 11-bit value.
  - in_win = rel_x non-negative AND rel_x < 2^(IMG_XBITS+SCALE_LOG2) AND pixel_y < 2^(IMG_YBITS+SCALE_LOG2).
  - read address = {front_buf, pixel_y[SCALE_LOG2+:IMG_YBITS], rel_x[SCALE_LOG2+:IMG_XBITS]}.
  - Cycle 1: synchronous RAM read; in_win is delayed one stage.
  - Cycle 2: image_rgb = in_win_d ? dout : BG_COLOR, and pix_valid = in_win_d.
- Page flip FSM (NUM_BUF=2), states IDLE and PENDING:
  - IDLE, swap_req && !frame_start -> PENDING.
  - IDLE, swap_req && frame_start -> toggle front_buf, stay IDLE (immediate apply).
  - PENDING, frame_start -> toggle front_buf, go to IDLE.
  - PENDING, swap_req -> no effect.
  - swap_pending = (state==PENDING).
- NUM_BUF=1: swap_req is ignored; front_buf=0 and swap_pending=0 permanently.
- Read/write to the same RAM word in the same cycle: the read returns old data (read-first).
- Reset mid-write: a write held in stage 1 is discarded.
- Reset while PENDING: the FSM returns to IDLE with front_buf=0.

Decomposition:
- vga_pkg holds:
  - the default constants (X_OFFSET, image bits, SCALE_LOG2);
  - the flip-state typedef enum {IDLE, PENDING};
  - a function computing RAM_AW.
- Storage reuses the existing sub-module dual_port_ram_sync, with ADDR_WIDTH=RAM_AW and DATA_WIDTH=DATA_W.
- Port a is the write port; port b is the read port.

Test Plan:
- Reset: assert reset with no clock edge. Outputs go 0 immediately. After release with no stimulus, pix_valid=0 at pixel (0,0).
- Basic display: write address=1 with data 8'hE0, pulse swap_req, then frame_start.
  - front_buf=1.
  - Pixels (240,0) and (243,3) give image_rgb=E0 with pix_valid=1, 2 cycles later.
  - Pixel (244,0) shows the data written at address 2.
- Window edges:
  - pixel_x=239 -> BG_COLOR, pix_valid=0.
  - pixel_x=751 -> in window.
  - pixel_x=752 -> BG.
  - pixel_y=511 -> in window.
  - pixel_y=512 -> BG.
- Address filter:
  - Write to address 0 with 8'hFF: RAM is unchanged.
  - Write to address 16385 (D+1) with 8'hFF: RAM is unchanged.
  - Write to address 16384 updates pixel (752-4, 508).
- Flip timing:
  - swap_req at cycle 10: swap_pending=1 from cycle 11, and front_buf is unchanged until frame_start.
  - A second swap_req while PENDING causes no extra toggle.
  - swap_req coincident with frame_start in IDLE: front_buf toggles next cycle and swap_pending stays 0.
- Tear-free write and reset mid-op:
  - With front_buf=1, writes land in bank 0, and the displayed pixels are unchanged until the flip.
  - Assert reset one cycle after image_we: the write is not performed, and front_buf=0, swap_pending=0.
